// File: rtl/addr_bus_6801_pkg.sv
// Shared 6801 core types: EA-unit control, bus-address control and bus FSM state.
// Pure declarations; no logic.
package addr_bus_6801_pkg;

    typedef enum logic [2:0] {
        reset_ea,
        load_ea,
        add_ea,
        fetch_first_ea,
        fetch_next_ea
    } ea_type;

    typedef enum logic [2:0] {
        idle_ad,
        fetch_ad,
        read_ad,
        write_ad,
        push_ad,
        pull_ad,
        int_hi_ad,
        int_lo_ad
    } addr_type;

    typedef enum logic {
        IDLE,
        WAIT
    } bus_state_t;

    localparam logic [15:0] VEC_BASE = 16'hFFF0;

endpackage

// File: rtl/addr_bus_6801_if.sv
// Core-to-bus-stage signal bundle: address sources and control in, bus and stall out.
// master = sequencer/datapath/memory side, slave = bus-cycle stage.
interface addr_bus_6801_if;
    import addr_bus_6801_pkg::*;

    addr_type    addr_ctrl;
    logic [15:0] pc;
    logic [15:0] ea;
    logic [15:0] sp;
    logic [2:0]  iv;
    logic [7:0]  dout;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic [15:0] addr;
    logic        vma;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  data_in;
    logic        hold;
    logic        bus_err;

    modport master (
        output addr_ctrl, pc, ea, sp, iv, dout, mem_ready, mem_rdata,
        input  addr, vma, rw, wdata, data_in, hold, bus_err
    );

    modport slave (
        input  addr_ctrl, pc, ea, sp, iv, dout, mem_ready, mem_rdata,
        output addr, vma, rw, wdata, data_in, hold, bus_err
    );

endinterface

// File: rtl/addr_bus_6801.sv
// Bus-cycle stage: address mux, vma/rw/wdata drive and wait-state insertion for slow memory.
// Fast access 1 cycle, slow 1+SLOW_WAIT or more; hold stalls the core until mem_ready or timeout.
module addr_bus_6801
    import addr_bus_6801_pkg::*;
#(
    parameter logic [7:0] SLOW_PAGE = 8'hBF,
    parameter int         SLOW_WAIT = 2,
    parameter int         TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    addr_bus_6801_if.slave    bus
);

    localparam int         TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The start cycle in IDLE already counts as the first slow wait cycle.
    localparam logic [3:0] CNT_LOAD = (SLOW_WAIT > 0) ? 4'(SLOW_WAIT - 1) : 4'd0;

    bus_state_t  state_q, state_d;
    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [7:0]  data_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [TW-1:0] tout_q, tout_d;

    logic [15:0] mux_addr;
    logic        mux_rw;
    logic        mux_vma;
    logic        slow;
    logic        tout_last;
    logic        latch;
    logic        cap_rd;
    logic        cap_ff;

    always_comb begin
        mux_addr = 16'hFFFF;
        mux_rw   = 1'b1;
        mux_vma  = 1'b1;
        case (bus.addr_ctrl)
            idle_ad:   mux_vma  = 1'b0;
            fetch_ad:  mux_addr = bus.pc;
            read_ad:   mux_addr = bus.ea;
            write_ad: begin
                mux_addr = bus.ea;
                mux_rw   = 1'b0;
            end
            push_ad: begin
                mux_addr = bus.sp;
                mux_rw   = 1'b0;
            end
            pull_ad:   mux_addr = bus.sp + 16'd1;
            int_hi_ad: mux_addr = VEC_BASE | {12'h000, bus.iv, 1'b0};
            int_lo_ad: mux_addr = VEC_BASE | {12'h000, bus.iv, 1'b1};
            default:   mux_vma  = 1'b0;
        endcase
    end

    assign slow      = mux_vma && (mux_addr[15:8] == SLOW_PAGE) && (SLOW_WAIT > 0);
    assign tout_last = (int'(tout_q) + 1) >= (TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tout_d      = tout_q;
        latch       = 1'b0;
        cap_rd      = 1'b0;
        cap_ff      = 1'b0;
        bus.addr    = mux_addr;
        bus.vma     = mux_vma;
        bus.rw      = mux_rw;
        bus.wdata   = bus.dout;
        bus.data_in = data_q;
        bus.hold    = 1'b0;
        bus.bus_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (mux_vma) begin
                    if (!slow && bus.mem_ready) begin
                        if (mux_rw) begin
                            bus.data_in = bus.mem_rdata;
                            cap_rd      = 1'b1;
                        end
                    end else begin
                        bus.hold = 1'b1;
                        latch    = 1'b1;
                        cnt_d    = slow ? CNT_LOAD : 4'd0;
                        tout_d   = '0;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                bus.addr  = addr_q;
                bus.vma   = 1'b1;
                bus.rw    = rw_q;
                bus.wdata = wdata_q;
                if (cnt_q != 4'd0) begin
                    cnt_d    = cnt_q - 4'd1;
                    bus.hold = 1'b1;
                end else if (bus.mem_ready) begin
                    if (rw_q) begin
                        bus.data_in = bus.mem_rdata;
                        cap_rd      = 1'b1;
                    end
                    state_d = IDLE;
                end else if (tout_last) begin
                    // Forced completion: reads return FF, writes are simply dropped.
                    bus.bus_err = 1'b1;
                    if (rw_q) begin
                        bus.data_in = 8'hFF;
                        cap_ff      = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    tout_d   = tout_q + TW'(1);
                    bus.hold = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            bus.addr    = 16'hFFFE;
            bus.vma     = 1'b0;
            bus.rw      = 1'b1;
            bus.hold    = 1'b0;
            bus.bus_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            tout_q  <= '0;
            data_q  <= 8'h00;
            addr_q  <= 16'h0000;
            rw_q    <= 1'b1;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            if (latch) begin
                addr_q  <= mux_addr;
                rw_q    <= mux_rw;
                wdata_q <= bus.dout;
            end
            if (cap_rd) begin
                data_q <= bus.mem_rdata;
            end else if (cap_ff) begin
                data_q <= 8'hFF;
            end
        end
    end

endmodule
